// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
// Latency: n/a; backpressure: n/a (constants only).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    localparam int DEF_MEM_LAT    = 2;
    localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// Loadable down-counter; done is high while the count equals 1.
// Latency: load visible next cycle; backpressure: none, free-running to 0.
module lat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory between fetch and data ports, data first with a fetch starvation guard.
// Latency: grant to ack MEM_LAT+1 cycles; backpressure: stall_if/stall_mem hold a port until its ack.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = DEF_MEM_LAT,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    arb_state_e        state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic              half_sel_q, half_sel_d;
    logic              store_q, store_d;
    logic              if_ack_q, if_ack_d;
    logic              dm_ack_q, dm_ack_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic elig_if, elig_dm, grant_vld, grant_port, lat_done;

    // A port acked this cycle is still holding its old request, so it sits out.
    always_comb begin
        elig_if    = if_req & ~if_ack_q;
        elig_dm    = dm_req & ~dm_ack_q;
        grant_vld  = ~reset & (state_q == IDLE) & (elig_if | elig_dm);
        grant_port = (elig_if & ((starve_q == 4'(STARVE_MAX)) | ~elig_dm)) ? PORT_IF : PORT_DM;

        mem_en    = grant_vld;
        mem_we    = grant_vld & (grant_port == PORT_DM) & dm_we;
        mem_addr  = '0;
        if (grant_vld) begin
            mem_addr = (grant_port == PORT_DM) ? dm_addr : if_addr;
        end
        mem_wdata = mem_we ? dm_wdata : '0;
    end

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        half_sel_d = half_sel_q;
        store_d    = store_q;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_vld && grant_port == PORT_DM) begin
                    state_d = BUSY_DM;
                    store_d = dm_we;
                end else if (grant_vld) begin
                    state_d    = BUSY_IF;
                    half_sel_d = if_addr[2];
                end
            end
            BUSY_IF: begin
                if (lat_done) begin
                    state_d    = IDLE;
                    if_ack_d   = 1'b1;
                    if_rdata_d = half_sel_q ? mem_rdata[63:32] : mem_rdata[31:0];
                end
            end
            BUSY_DM: begin
                if (lat_done) begin
                    state_d  = IDLE;
                    dm_ack_d = 1'b1;
                    if (!store_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!if_req) begin
            starve_d = '0;
        end else if (grant_vld && grant_port == PORT_IF) begin
            starve_d = '0;
        end else if (grant_vld && starve_q < 4'(STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            half_sel_q <= 1'b0;
            store_q    <= 1'b0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            half_sel_q <= half_sel_d;
            store_q    <= store_d;
            if_ack_q   <= if_ack_d;
            dm_ack_q   <= dm_ack_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    lat_counter #(.W(4)) u_lat (
        .clk      (clk),
        .reset    (reset),
        .load     (grant_vld),
        .load_val (4'(MEM_LAT)),
        .done     (lat_done)
    );

    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign stall_if  = if_req & ~if_ack_q;
    assign stall_mem = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed literal cases plus randomized traffic against a cycle-number model.
module tb_mem_arbiter;

    localparam int LAT = 2;
    localparam int SM  = 2;

    logic        clk, reset;
    logic        if_req, dm_req, dm_we;
    logic [63:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_rdata;
    logic [63:0] dm_rdata, mem_addr, mem_wdata;
    logic        if_ack, dm_ack, mem_en, mem_we, stall_if, stall_mem;

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(LAT), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_on = 0;

    logic [63:0] mem [0:255];
    bit   [15:0] rsp_vld;
    logic [63:0] rsp_dat [0:15];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Memory: read snapshot and write both happen at issue; data appears exactly LAT cycles later.
    initial begin
        int s;
        mem_rdata = '0;
        rsp_vld   = '0;
        forever begin
            @(negedge clk);
            if (mem_en) begin
                s = (cyc + LAT) % 16;
                rsp_vld[s] = 1'b1;
                rsp_dat[s] = mem[mem_addr[10:3]];
                if (mem_we) mem[mem_addr[10:3]] = mem_wdata;
            end
            @(posedge clk);
            #1;
            s = cyc % 16;
            if (rsp_vld[s]) begin
                mem_rdata  = rsp_dat[s];
                rsp_vld[s] = 1'b0;
            end else begin
                mem_rdata = {$urandom, $urandom};
            end
        end
    end

    // Reference model: a port issued at cycle c is acked at c+LAT+1; the arbiter is free again that cycle.
    int          free_at = 0, if_iss = -1000, dm_iss = -1000, starve = 0;
    bit          dm_iss_we;
    logic [31:0] if_exp, e_if_rdata = '0;
    logic [63:0] dm_exp, e_dm_rdata = '0, w;
    initial forever begin
        bit e_if_ack, e_dm_ack, el_if, el_dm, g_if, g_dm;
        @(negedge clk);
        e_if_ack = (if_iss == cyc - LAT - 1);
        e_dm_ack = (dm_iss == cyc - LAT - 1);
        if (e_if_ack) e_if_rdata = if_exp;
        if (e_dm_ack && !dm_iss_we) e_dm_rdata = dm_exp;
        g_if = 0;
        g_dm = 0;
        if (!reset && cyc >= free_at) begin
            el_if = if_req && !e_if_ack;
            el_dm = dm_req && !e_dm_ack;
            if (el_if && (starve == SM || !el_dm)) g_if = 1;
            else if (el_dm) g_dm = 1;
        end
        if (chk_on) begin
            chk("m_if_ack", if_ack, e_if_ack);
            chk("m_dm_ack", dm_ack, e_dm_ack);
            chk("m_if_rdata", if_rdata, e_if_rdata);
            chk("m_dm_rdata", dm_rdata, e_dm_rdata);
            chk("m_mem_en", mem_en, g_if | g_dm);
            chk("m_mem_we", mem_we, g_dm & dm_we);
            chk("m_mem_wdata", mem_wdata, (g_dm && dm_we) ? dm_wdata : 64'h0);
            chk("m_stall_if", stall_if, if_req & ~e_if_ack);
            chk("m_stall_mem", stall_mem, dm_req & ~e_dm_ack);
            if (g_if | g_dm) chk("m_mem_addr", mem_addr, g_dm ? dm_addr : if_addr);
        end
        if (reset) begin
            free_at = cyc + 1;
            if_iss = -1000;
            dm_iss = -1000;
            starve = 0;
            e_if_rdata = '0;
            e_dm_rdata = '0;
        end else begin
            if (g_if) begin
                w       = mem[if_addr[10:3]];
                if_exp  = if_addr[2] ? w[63:32] : w[31:0];
                if_iss  = cyc;
                free_at = cyc + LAT + 1;
            end
            if (g_dm) begin
                dm_exp    = mem[dm_addr[10:3]];
                dm_iss_we = dm_we;
                dm_iss    = cyc;
                free_at   = cyc + LAT + 1;
            end
            if (!if_req || g_if) starve = 0;
            else if (g_dm && starve < SM) starve++;
        end
    end

    task automatic run_load(input logic [63:0] addr, input logic [63:0] exp);
        next_cycle();
        dm_req = 1; dm_we = 0; dm_addr = addr;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) next_cycle();
            @(negedge clk);
            chk("load_mem_en", mem_en, k == 0);
            chk("load_dm_ack", dm_ack, k == 3);
            chk("load_stall_mem", stall_mem, k < 3);
        end
        chk("load_dm_rdata", dm_rdata, exp);
        next_cycle();
        dm_req = 0;
    endtask

    task automatic run_fetch(input logic [63:0] addr, input logic [31:0] exp);
        next_cycle();
        if_req = 1; if_addr = addr;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) next_cycle();
            @(negedge clk);
            chk("fetch_mem_en", mem_en, k == 0);
            chk("fetch_if_ack", if_ack, k == 3);
            chk("fetch_stall_if", stall_if, k < 3);
        end
        chk("fetch_if_rdata", if_rdata, exp);
        next_cycle();
        if_req = 0;
    endtask

    function automatic logic [63:0] raddr(input bit fetch);
        logic [63:0] a;
        a = 64'($urandom_range(0, 255)) << 3;
        if (fetch) a[2] = 1'($urandom_range(0, 1));
        return a;
    endfunction

    initial begin
        int ng;
        bit pif, pdm;
        reset = 1; if_req = 0; dm_req = 0; dm_we = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        mem[8'h08] = 64'hDEADBEEF_CAFEF00D;
        mem[8'h20] = 64'h11111111_22222222;
        mem[8'h0A] = 64'h01234567_89ABCDEF;

        next_cycle();
        next_cycle();
        reset = 0;
        chk_on = 1;
        @(negedge clk);
        chk("rst_if_ack", if_ack, 0);
        chk("rst_dm_ack", dm_ack, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);

        run_load(64'h40, 64'hDEADBEEF_CAFEF00D);
        run_fetch(64'h104, 32'h11111111);
        run_fetch(64'h100, 32'h22222222);

        next_cycle();
        dm_req = 1; dm_we = 0; dm_addr = 64'h40; if_req = 1; if_addr = 64'h100;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) next_cycle();
            if (k == 4) dm_req = 0;
            @(negedge clk);
            chk("cont_dm_ack", dm_ack, k == 3);
            chk("cont_if_ack", if_ack, k == 6);
            chk("cont_mem_en", mem_en, (k == 0) || (k == 3));
            chk("cont_stall_if", stall_if, k < 6);
        end
        next_cycle();
        if_req = 0;

        // Both held: the data ack cycle makes data ineligible, so fetch takes it and grants alternate.
        next_cycle();
        dm_req = 1; dm_we = 0; dm_addr = 64'h40; if_req = 1; if_addr = 64'h100;
        ng = 0;
        for (int k = 0; k < 19; k++) begin
            if (k > 0) next_cycle();
            if (k == 16) dm_req = 0;
            @(negedge clk);
            if (mem_en) begin
                chk("starve_order", mem_addr, (ng % 2 == 0) ? 64'h40 : 64'h100);
                ng++;
            end
        end
        chk("starve_grants", 64'(ng), 6);
        next_cycle();
        if_req = 0;

        next_cycle();
        dm_req = 1; dm_we = 1; dm_addr = 64'h48; dm_wdata = {8{8'hA5}};
        for (int k = 0; k < 4; k++) begin
            if (k > 0) next_cycle();
            @(negedge clk);
            if (k == 0) begin
                chk("store_mem_we", mem_we, 1);
                chk("store_mem_wdata", mem_wdata, {8{8'hA5}});
            end
            if (k == 1) chk("store_wdata_idle", mem_wdata, 0);
            chk("store_dm_ack", dm_ack, k == 3);
        end
        chk("store_dm_rdata", dm_rdata, 64'hDEADBEEF_CAFEF00D);
        next_cycle();
        dm_req = 0; dm_we = 0;

        next_cycle();
        dm_req = 1; dm_we = 0; dm_addr = 64'h50;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) next_cycle();
            if (k == 1) begin reset = 1; dm_req = 0; end
            if (k == 2) reset = 0;
            @(negedge clk);
            chk("rstmid_dm_ack", dm_ack, 0);
            if (k >= 2) begin
                chk("rstmid_dm_rdata", dm_rdata, 0);
                chk("rstmid_if_rdata", if_rdata, 0);
                chk("rstmid_mem_en", mem_en, 0);
            end
        end
        run_load(64'h50, 64'h01234567_89ABCDEF);

        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            pif = if_ack;
            pdm = dm_ack;
            next_cycle();
            if (!if_req || pif) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = raddr(1);
            end
            if (!dm_req || pdm) begin
                dm_req   = ($urandom_range(0, 2) != 0);
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = raddr(0);
                dm_wdata = {$urandom, $urandom};
            end
            reset = ($urandom_range(0, 149) == 0);
        end
        next_cycle();
        reset = 0; if_req = 0; dm_req = 0;
        repeat (6) next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
